// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Uses a fixed WIDTH-step shift-add multiply or restoring divide on operand
// magnitudes. Signs are fixed up in the FINISH cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             is_div_q, neg_q_q, neg_r_q, dz_q;
  logic [WIDTH-1:0] a_q;    // raw dividend, returned as HI on divide-by-zero
  logic [WIDTH-1:0] d_q;    // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc_q;  // product high half / partial remainder
  logic [WIDTH-1:0] qr_q;   // multiplier bits / dividend-to-quotient bits
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mult_sum, div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] acc_d, qr_d;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] res_hi_d, res_lo_d;

  // Operand magnitudes for the signed ops (op[0] == 0 means signed)
  always_comb begin
    a_neg = ~op[0] & a[WIDTH-1];
    b_neg = ~op[0] & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // One iteration step: shift-add for multiply, restoring subtract for divide
  always_comb begin
    mult_sum = {1'b0, acc_q} + (qr_q[0] ? {1'b0, d_q} : '0);
    div_sh   = {acc_q, qr_q[WIDTH-1]};
    div_ge   = div_sh >= {1'b0, d_q};
    if (is_div_q) begin
      acc_d = div_ge ? WIDTH'(div_sh - {1'b0, d_q}) : div_sh[WIDTH-1:0];
      qr_d  = {qr_q[WIDTH-2:0], div_ge};
    end else begin
      acc_d = mult_sum[WIDTH:1];
      qr_d  = {mult_sum[0], qr_q[WIDTH-1:1]};
    end
  end

  // Sign correction and special cases for the final HI/LO write
  always_comb begin
    prod     = {acc_q, qr_q};
    prod_fix = neg_q_q ? -prod : prod;
    if (!is_div_q) begin
      res_hi_d = prod_fix[2*WIDTH-1:WIDTH];
      res_lo_d = prod_fix[WIDTH-1:0];
    end else if (dz_q) begin
      res_hi_d = a_q;
      res_lo_d = '1;
    end else begin
      res_hi_d = neg_r_q ? -acc_q : acc_q;
      res_lo_d = neg_q_q ? -qr_q : qr_q;
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      a_q      <= '0;
      d_q      <= '0;
      acc_q    <= '0;
      qr_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            is_div_q <= op[1];
            neg_q_q  <= a_neg ^ b_neg;
            neg_r_q  <= a_neg;
            dz_q     <= op[1] & (b == '0);
            a_q      <= a;
            acc_q    <= '0;
            d_q      <= op[1] ? b_mag : a_mag;
            qr_q     <= op[1] ? a_mag : b_mag;
          end else begin
            if (mthi) hi_q <= wdata;
            if (mtlo) lo_q <= wdata;
          end
        end
        RUN: begin
          if (abort) begin
            state_q <= IDLE;
          end else begin
            acc_q <= acc_d;
            qr_q  <= qr_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) state_q <= FINISH;
          end
        end
        FINISH: begin
          state_q <= IDLE;
          if (!abort) begin
            hi_q   <= res_hi_d;
            lo_q   <= res_lo_d;
            done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + random checks of muldiv_unit at WIDTH = 32 using a result queue.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, abort, mthi, mtlo;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  typedef struct { logic [W-1:0] hi; logic [W-1:0] lo; } res_t;
  res_t sbq[$];

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .abort(abort), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    res_t r;
    longint sx, sy, sp;
    longint unsigned ux, uy, up;
    int ix, iy;
    sx = longint'($signed(x)); sy = longint'($signed(y));
    ux = {32'h0, x};           uy = {32'h0, y};
    ix = $signed(x);           iy = $signed(y);
    case (o)
      2'b00: begin sp = sx * sy; r.hi = sp[63:32]; r.lo = sp[31:0]; end
      2'b01: begin up = ux * uy; r.hi = up[63:32]; r.lo = up[31:0]; end
      2'b10: begin
        if (y == 0) begin r.hi = x; r.lo = '1; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin r.hi = '0; r.lo = x; end
        else begin r.lo = ix / iy; r.hi = ix % iy; end
      end
      default: begin
        if (y == 0) begin r.hi = x; r.lo = '1; end
        else begin r.lo = x / y; r.hi = x % y; end
      end
    endcase
    return r;
  endfunction

  // Called just after a negedge; returns just after the negedge where done is seen.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input bit with_abort, input bit with_mt);
    logic [W-1:0] hi0, lo0;
    int n, bc;
    bit held;
    res_t r;
    hi0 = hi; lo0 = lo;
    start = 1'b1; op = o; a = x; b = y;
    abort = with_abort; mthi = with_mt; mtlo = with_mt; wdata = 32'hDEAD_BEEF;
    sbq.push_back(model(o, x, y));
    @(negedge clk);
    start = 1'b0; abort = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    n = 0; bc = 0; held = 1'b1;
    while (!done && n < 100) begin
      if (busy) bc++;
      if (hi !== hi0 || lo !== lo0) held = 1'b0;
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(W + 1));
    chk({tag, "_busy_cycles"}, 64'(bc), 64'(W + 1));
    chk({tag, "_hilo_held"}, 64'(held), 64'd1);
    if (sbq.size() > 0) begin
      r = sbq.pop_front();
      chk({tag, "_hi"}, 64'(hi), 64'(r.hi));
      chk({tag, "_lo"}, 64'(lo), 64'(r.lo));
    end
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 64'(done), 64'd0);
  endtask

  initial begin
    int cyc, last, ndone, seen;
    res_t r;
    logic [W-1:0] hsave;
    reset = 1'b1; start = 1'b0; abort = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);

    do_op("multu_7x6", 2'b01, 32'd7, 32'd6, 1'b0, 1'b0);
    chk("multu_7x6_lo_const", 64'(lo), 64'h2A);
    do_op("mult_m3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    do_op("divu_100_7", 2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
    chk("divu_100_7_q", 64'(lo), 64'd14);
    do_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    chk("div_m7_2_q", 64'(lo), 64'hFFFF_FFFD);
    do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op("divu_by0", 2'b11, 32'h1234, 32'd0, 1'b0, 1'b0);
    chk("divu_by0_hi", 64'(hi), 64'h1234);
    do_op("div_by0", 2'b10, 32'h8000_0005, 32'd0, 1'b0, 1'b0);
    do_op("start_abort_idle", 2'b01, 32'd9, 32'd9, 1'b1, 1'b0);
    do_op("start_mt_idle", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);

    // mthi/mtlo in IDLE, abort in IDLE
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_0001;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mt_both_hi", 64'(hi), 64'hA5A5_0001);
    chk("mt_both_lo", 64'(lo), 64'hA5A5_0001);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle_busy", 64'(busy), 64'd0);
    chk("abort_idle_hi", 64'(hi), 64'hA5A5_0001);

    // abort mid-run
    mtlo = 1'b1; wdata = 32'h55;
    @(negedge clk);
    mtlo = 1'b0;
    chk("mtlo_55", 64'(lo), 64'h55);
    hsave = hi;
    start = 1'b1; op = 2'b01; a = 32'd7; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    chk("abort_busy_drop", 64'(busy), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen++;
      @(negedge clk);
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    chk("abort_lo", 64'(lo), 64'h55);
    chk("abort_hi", 64'(hi), 64'(hsave));

    // reset mid-run
    start = 1'b1; op = 2'b01; a = 32'd7; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid_busy", 64'(busy), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen++;
      @(negedge clk);
    end
    chk("rstmid_no_done", 64'(seen), 64'd0);
    chk("rstmid_hi", 64'(hi), 64'd0);
    chk("rstmid_lo", 64'(lo), 64'd0);

    // continuous start, mthi pulses while busy
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd5; wdata = 32'hBAD;
    sbq.push_back(model(2'b01, 32'd3, 32'd5));
    cyc = 0; last = -1; ndone = 0;
    while (ndone < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      mthi = (cyc % 7 == 3);
      if (done) begin
        if (sbq.size() > 0) begin
          r = sbq.pop_front();
          chk("b2b_hi", 64'(hi), 64'(r.hi));
          chk("b2b_lo", 64'(lo), 64'(r.lo));
        end
        if (last >= 0) chk("b2b_spacing", 64'(cyc - last), 64'(W + 2));
        last = cyc;
        ndone++;
        if (ndone < 3) sbq.push_back(model(2'b01, 32'd3, 32'd5));
        else start = 1'b0;
      end
    end
    mthi = 1'b0;
    chk("b2b_count", 64'(ndone), 64'd3);
    @(negedge clk);
    chk("b2b_idle_after", 64'(busy), 64'd0);

    // random operations against the model
    for (int i = 0; i < 8; i++) begin
      logic [1:0] ro;
      logic [W-1:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 5) ? 32'd0 : ((i % 2) ? 32'($urandom_range(1, 1000)) : $urandom);
      do_op("rand", ro, ra, rb, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width (legal range 8..64).
REQ-002 SHALL use one clock; reset is synchronous and active-high. Ports: clk  input  1  rising-edge clock; reset  input  1  synchronous active-high reset.
REQ-003 SHALL have ports: start  input  1  request new operation; op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-004 SHALL have ports: a  input  WIDTH  multiplicand/dividend; b  input  WIDTH  multiplier/divisor.
REQ-005 SHALL have ports: abort  input  1  cancel in-flight op; mthi  input  1  write hi; mtlo  input  1  write lo; wdata  input  WIDTH  mthi/mtlo data.
REQ-006 SHALL have ports: busy  output  1  op in flight; done  output  1  one-cycle completion pulse; hi  output  WIDTH  HI register; lo  output  WIDTH  LO register.

Function
REQ-007 SHALL implement FSM IDLE -> RUN -> FINISH -> IDLE; busy = (state != IDLE).
REQ-008 SHALL accept start only in IDLE; a, b, op are captured at the accepting edge; start while busy is ignored (no queueing).
REQ-009 SHALL stay in RUN for exactly WIDTH cycles, one shift-add (multiply) or restoring-subtract (divide) step per cycle.
REQ-010 SHALL, in FINISH, apply sign correction, write hi/lo, return to IDLE; done = 1 for exactly the one cycle following that edge.
REQ-011 SHALL give fixed latency: start accepted at edge E0 -> hi/lo and done valid after edge E(WIDTH+1), independent of operand values.
REQ-012 SHALL hold hi/lo unchanged from acceptance until the FINISH write; hi/lo reflect the previous result while busy.
REQ-013 MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product, two's-complement for MULT, unsigned for MULTU.
REQ-014 DIV/DIVU: lo = quotient, hi = remainder; signed quotient truncates toward zero; signed remainder takes dividend's sign.
REQ-015 Divide by zero (b == 0): lo = all ones, hi = a; same latency, done still pulses.
REQ-016 Signed overflow (a = most negative, b = -1, DIV): lo = a (wraps), hi = 0.
REQ-017 abort in RUN or FINISH: next state IDLE, hi/lo unchanged, no done pulse; abort in IDLE has no effect.
REQ-018 abort and start in the same cycle while busy: abort wins, start ignored; start with abort in IDLE: start accepted.
REQ-019 mthi/mtlo in IDLE write wdata to hi/lo at the next edge; both asserted write both; ignored while busy.
REQ-020 start together with mthi/mtlo in IDLE: start accepted, mthi/mtlo ignored.
REQ-021 start in the done cycle (state IDLE) SHALL be accepted, giving back-to-back ops every WIDTH+2 cycles.

Reset
REQ-022 reset SHALL force state IDLE, busy = 0, done = 0, hi = 0, lo = 0 at the next edge, overriding all other inputs including mid-operation.
REQ-023 reset during RUN/FINISH SHALL discard the in-flight op with no done pulse.

Verification (WIDTH = 32)
REQ-024 MULTU a=7, b=6 -> busy for 33 cycles, done pulse after edge 33, hi=0x00000000, lo=0x0000002A.
REQ-025 MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIVU a=100, b=7 -> lo=14, hi=2.
REQ-026 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-027 DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234, done at normal latency.
REQ-028 mtlo wdata=0x55 then MULTU, abort at cycle 10 -> busy drops next cycle, no done, lo=0x55; repeat with reset at cycle 10 -> hi=lo=0.
REQ-029 start asserted continuously with mthi pulses and start during busy -> only ops accepted in IDLE execute, done spaced exactly 34 cycles, mthi while busy has no effect.
